// File: rtl/cam_stream_gen_pkg.sv
// Shared types and constants for the synthetic camera stream generator.
// States follow the frame: sync pulse, back porch, active lines, front porch.
package cam_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } camState_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    // Counter width for a count of maxCount states, never narrower than one bit.
    function automatic int widthFor(input int maxCount);
        return (maxCount > 1) ? $clog2(maxCount) : 1;
    endfunction

    function automatic int maxOf4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// OV7670-style parallel camera bus: pixel clock, frame/line syncs and pixel byte.
// The generator drives it as master; a camera receiver consumes it as slave.
interface cam_stream_gen_if;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (output cam_pclk, output cam_vsync, output cam_href, output cam_data);
    modport slave  (input  cam_pclk, input  cam_vsync, input  cam_href, input  cam_data);
endinterface

// File: rtl/cam_stream_gen_pattern.sv
// Combinational test-pattern lookup: maps a pixel position and pattern code to a byte.
// Coordinates are zero-extended first so narrow counters still index bits 5 and 7:0.
module cam_pattern_gen
    import cam_stream_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [1:0]    pattern_i,
    input  logic [7:0]    fill_i,
    output logic [7:0]    pixel_o
);

    logic [31:0] xWide;
    logic [31:0] yWide;

    assign xWide = 32'(x_i);
    assign yWide = 32'(y_i);

    always_comb begin
        pixel_o = 8'h00;
        case (pattern_i)
            PAT_HRAMP: pixel_o = xWide[7:0];
            PAT_VRAMP: pixel_o = yWide[7:0];
            PAT_CHECK: pixel_o = (xWide[5] ^ yWide[5]) ? 8'hFF : 8'h00;
            PAT_SOLID: pixel_o = fill_i;
            default:   pixel_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// Synthetic camera transmitter: divides the system clock into a pixel clock and
// walks a full frame timing, updating every bus output on the pclk falling edge.
module cam_stream_gen
    import cam_stream_pkg::*;
#(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int PCLK_DIV      = 4,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10
) (
    input  logic                   clk_100mhz,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic [1:0]             patternSel_i,
    input  logic [7:0]             fillLevel_i,
    cam_stream_gen_if.master       cam,
    output logic                   frameDone_o,
    output logic [15:0]            frameCount_o
);

    localparam int LINE_LEN = IMG_WIDTH + H_BLANK;
    localparam int DIV_W    = widthFor(PCLK_DIV);
    localparam int COL_W    = widthFor(LINE_LEN);
    localparam int LINE_W   = widthFor(maxOf4(VSYNC_LINES, V_BACK_LINES, IMG_HEIGHT, V_FRONT_LINES));

    camState_t          state_q, stateD;
    logic [DIV_W-1:0]   div_q, divD;
    logic [COL_W-1:0]   col_q, colD;
    logic [LINE_W-1:0]  line_q, lineD;
    logic [1:0]         patSel_q, patSelD;
    logic [7:0]         fill_q, fillD;
    logic               pclk_q, vsync_q, href_q, frameDone_q;
    logic [7:0]         data_q;
    logic [15:0]        frameCount_q;
    logic               tick, lastCol, frameEnd, hrefD;
    logic [7:0]         pixel;

    assign tick    = (div_q == DIV_W'(PCLK_DIV - 1));
    assign divD    = tick ? '0 : div_q + 1'b1;
    assign lastCol = (col_q == COL_W'(LINE_LEN - 1));

    // Position of the pixel that will be on the bus after the coming tick.
    always_comb begin
        stateD   = state_q;
        colD     = col_q;
        lineD    = line_q;
        patSelD  = patSel_q;
        fillD    = fill_q;
        frameEnd = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable_i) begin
                stateD  = ST_VSYNC;
                colD    = '0;
                lineD   = '0;
                patSelD = patternSel_i;
                fillD   = fillLevel_i;
            end
        end else begin
            colD = lastCol ? '0 : col_q + 1'b1;
            if (lastCol) begin
                lineD = line_q + 1'b1;
                case (state_q)
                    ST_VSYNC: if (line_q == LINE_W'(VSYNC_LINES - 1)) begin
                        stateD = ST_VBACK;
                        lineD  = '0;
                    end
                    ST_VBACK: if (line_q == LINE_W'(V_BACK_LINES - 1)) begin
                        stateD = ST_ACTIVE;
                        lineD  = '0;
                    end
                    ST_ACTIVE: if (line_q == LINE_W'(IMG_HEIGHT - 1)) begin
                        stateD = ST_VFRONT;
                        lineD  = '0;
                    end
                    ST_VFRONT: if (line_q == LINE_W'(V_FRONT_LINES - 1)) begin
                        frameEnd = 1'b1;
                        lineD    = '0;
                        stateD   = enable_i ? ST_VSYNC : ST_IDLE;
                        if (enable_i) begin
                            patSelD = patternSel_i;
                            fillD   = fillLevel_i;
                        end
                    end
                    default: lineD = '0;
                endcase
            end
        end
    end

    assign hrefD = (stateD == ST_ACTIVE) && (colD < COL_W'(IMG_WIDTH));

    cam_pattern_gen #(
        .XW (COL_W),
        .YW (LINE_W)
    ) uPattern (
        .x_i       (colD),
        .y_i       (lineD),
        .pattern_i (patSelD),
        .fill_i    (fillD),
        .pixel_o   (pixel)
    );

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            pclk_q       <= 1'b0;
            state_q      <= ST_IDLE;
            col_q        <= '0;
            line_q       <= '0;
            patSel_q     <= PAT_HRAMP;
            fill_q       <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frameDone_q  <= 1'b0;
            frameCount_q <= 16'h0000;
        end else begin
            div_q       <= divD;
            pclk_q      <= (divD >= DIV_W'(PCLK_DIV / 2));
            frameDone_q <= 1'b0;
            if (tick) begin
                state_q     <= stateD;
                col_q       <= colD;
                line_q      <= lineD;
                patSel_q    <= patSelD;
                fill_q      <= fillD;
                vsync_q     <= (stateD == ST_VSYNC);
                href_q      <= hrefD;
                data_q      <= hrefD ? pixel : 8'h00;
                frameDone_q <= frameEnd;
                if (frameEnd) begin
                    frameCount_q <= frameCount_q + 1'b1;
                end
            end
        end
    end

    assign cam.cam_pclk  = pclk_q;
    assign cam.cam_vsync = vsync_q;
    assign cam.cam_href  = href_q;
    assign cam.cam_data  = data_q;
    assign frameDone_o   = frameDone_q;
    assign frameCount_o  = frameCount_q;

endmodule
